mac_dot_acc: RTL

// - Parametrised multi-lane multiply-accumulate unit: LANES unsigned activations x signed weights per beat.
// - Lanes reduce to one dot product, accumulated over a group of beats ending in in_last; one psum per group.
// - Sits between the activation/weight feed and the psum writeback path of the array.
// - Pipelined: stage 1 registers the dot product, stage 2 accumulates and emits the result.

---
 rtl/mac_dot_acc_pkg.sv | 37 +++
 rtl/mac_dot_acc_if.sv | 27 ++
 rtl/mac_dot_acc_lanes.sv | 37 +++
 rtl/mac_dot_acc.sv | 117 +++++++++++
 4 files changed

// File: rtl/mac_dot_acc_pkg.sv
// mac_pkg: default widths, derived width constants and clamp helpers shared by
// the multiply-accumulate unit and its lane reduction sub-module.
// No ports; imported with import mac_pkg::*.
package mac_pkg;

  localparam int DEF_BW      = 4;
  localparam int DEF_LANES   = 4;
  localparam int DEF_PSUM_BW = 16;

  // A lane product of an unsigned BW-bit and a signed BW-bit value fits 2*BW+1 bits;
  // summing LANES of them needs clog2(LANES) extra bits so the dot product is exact.
  localparam int DEF_PROD_BW = 2 * DEF_BW + 1;
  localparam int DEF_DOT_BW  = DEF_PROD_BW + $clog2(DEF_LANES);

  localparam longint DEF_PSUM_MAX = (longint'(1) <<< (DEF_PSUM_BW - 1)) - 1;
  localparam longint DEF_PSUM_MIN = -DEF_PSUM_MAX - 1;

  // Largest value representable in a signed psumBw-bit accumulator.
  function automatic longint psumMax(input int psumBw);
    return (longint'(1) <<< (psumBw - 1)) - 1;
  endfunction

  // Smallest value representable in a signed psumBw-bit accumulator.
  function automatic longint psumMin(input int psumBw);
    return -psumMax(psumBw) - 1;
  endfunction

  // Clamp a wide signed value to the nearest bound of the signed psumBw-bit range.
  function automatic longint clampPsum(input longint v, input int psumBw);
    longint r;
    r = v;
    if (v > psumMax(psumBw)) r = psumMax(psumBw);
    if (v < psumMin(psumBw)) r = psumMin(psumBw);
    return r;
  endfunction

endpackage

// File: rtl/mac_dot_acc_if.sv
// mac_dot_acc_if: beat input and group-result output bundle of the MAC unit.
//   in_valid/in_last/a/b : feed -> MAC (beat, end-of-group marker, lane operands)
//   out/out_valid/out_ovf : MAC -> writeback (signed group result, pulse, overflow flag)
// master = feed/writeback side, slave = the MAC itself.
interface mac_dot_acc_if #(
  parameter int BW      = 4,
  parameter int LANES   = 4,
  parameter int PSUM_BW = 16
);
  logic                      in_valid;
  logic                      in_last;
  logic [LANES*BW-1:0]       a;
  logic [LANES*BW-1:0]       b;
  logic signed [PSUM_BW-1:0] out;
  logic                      out_valid;
  logic                      out_ovf;

  modport master (
    output in_valid, in_last, a, b,
    input  out, out_valid, out_ovf
  );

  modport slave (
    input  in_valid, in_last, a, b,
    output out, out_valid, out_ovf
  );
endinterface

// File: rtl/mac_dot_acc_lanes.sv
// mac_dot_lanes: combinational LANES-way multiply and adder tree.
//   a_i   : LANES unsigned BW-bit activations, lane i at a_i[i*BW +: BW]
//   b_i   : LANES signed BW-bit weights, lane i at b_i[i*BW +: BW]
//   dot_o : exact signed sum of the lane products, DOT_BW bits
module mac_dot_lanes import mac_pkg::*; #(
  parameter int BW     = DEF_BW,
  parameter int LANES  = DEF_LANES,
  parameter int DOT_BW = 2 * BW + 1 + $clog2(LANES)
) (
  input  logic [LANES*BW-1:0]      a_i,
  input  logic [LANES*BW-1:0]      b_i,
  output logic signed [DOT_BW-1:0] dot_o
);

  localparam int PROD_BW = 2 * BW + 1;

  logic signed [PROD_BW-1:0] aExt;
  logic signed [PROD_BW-1:0] bExt;
  logic signed [PROD_BW-1:0] prod;

  // Each activation gets a zero sign bit so it multiplies as a non-negative signed
  // value; both operands are widened to the product width first so the multiply
  // is exact, then each product is sign-extended into the running dot sum.
  always_comb begin
    aExt  = '0;
    bExt  = '0;
    prod  = '0;
    dot_o = '0;
    for (int i = 0; i < LANES; i++) begin
      aExt  = PROD_BW'($signed({1'b0, a_i[i*BW +: BW]}));
      bExt  = PROD_BW'($signed(b_i[i*BW +: BW]));
      prod  = aExt * bExt;
      dot_o = dot_o + DOT_BW'(prod);
    end
  end

endmodule

// File: rtl/mac_dot_acc.sv
// mac_dot_acc: pipelined multi-lane multiply-accumulate producing one psum per group.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of mac_dot_acc_if (beat in, group result out)
// Stage 1 registers the lane dot product; stage 2 accumulates it over a group of
// beats and emits the result with an overflow flag when the group's last beat lands.
module mac_dot_acc import mac_pkg::*; #(
  parameter int BW      = DEF_BW,
  parameter int LANES   = DEF_LANES,
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int SAT     = 0
) (
  input logic         clk,
  input logic         reset,
  mac_dot_acc_if.slave bus
);

  localparam int PROD_BW = 2 * BW + 1;
  localparam int DOT_BW  = PROD_BW + $clog2(LANES);
  // One bit wider than either addend so base + dot can never wrap before the range check.
  localparam int FULL_BW = ((PSUM_BW > DOT_BW) ? PSUM_BW : DOT_BW) + 1;

  logic signed [DOT_BW-1:0]  dot;
  logic signed [DOT_BW-1:0]  dot_q;
  logic                      v1_q;
  logic                      l1_q;
  logic signed [PSUM_BW-1:0] acc_q,       acc_d;
  logic                      start_q,     start_d;
  logic                      sticky_q,    sticky_d;
  logic signed [PSUM_BW-1:0] out_q,       out_d;
  logic                      outValid_q,  outValid_d;
  logic                      outOvf_q,    outOvf_d;

  logic signed [FULL_BW-1:0] base;
  logic signed [FULL_BW-1:0] full;
  longint                    fullL;
  logic                      ovfNow;
  logic signed [PSUM_BW-1:0] result;

  mac_dot_lanes #(
    .BW    (BW),
    .LANES (LANES),
    .DOT_BW(DOT_BW)
  ) uLanes (
    .a_i  (bus.a),
    .b_i  (bus.b),
    .dot_o(dot)
  );

  // Stage 2 arithmetic: the first beat of a group starts from zero instead of the
  // stale accumulator, the sum is formed wide, then checked against the psum range
  // and either clamped or truncated depending on SAT.
  always_comb begin
    base   = start_q ? '0 : FULL_BW'(acc_q);
    full   = base + FULL_BW'(dot_q);
    fullL  = longint'(full);
    ovfNow = (fullL > psumMax(PSUM_BW)) || (fullL < psumMin(PSUM_BW));
    if (SAT != 0) result = PSUM_BW'(clampPsum(fullL, PSUM_BW));
    else          result = full[PSUM_BW-1:0];
  end

  // Stage 2 next state: a last beat publishes the result and re-arms the group
  // start; any other beat folds into the accumulator. Bubbles leave everything
  // alone except the output pulse, which drops.
  always_comb begin
    acc_d      = acc_q;
    start_d    = start_q;
    sticky_d   = sticky_q;
    out_d      = out_q;
    outOvf_d   = outOvf_q;
    outValid_d = 1'b0;
    if (v1_q) begin
      if (l1_q) begin
        out_d      = result;
        outOvf_d   = sticky_q | ovfNow;
        outValid_d = 1'b1;
        start_d    = 1'b1;
        sticky_d   = 1'b0;
      end else begin
        acc_d    = result;
        start_d  = 1'b0;
        sticky_d = sticky_q | ovfNow;
      end
    end
  end

  // Pipeline registers. Reset wipes the in-flight beat and partial group so a
  // group interrupted by reset never produces a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dot_q      <= '0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      acc_q      <= '0;
      start_q    <= 1'b1;
      sticky_q   <= 1'b0;
      out_q      <= '0;
      outValid_q <= 1'b0;
      outOvf_q   <= 1'b0;
    end else begin
      dot_q      <= dot;
      v1_q       <= bus.in_valid;
      l1_q       <= bus.in_valid & bus.in_last;
      acc_q      <= acc_d;
      start_q    <= start_d;
      sticky_q   <= sticky_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      outOvf_q   <= outOvf_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_ovf   = outOvf_q;

endmodule
